seg7_scan_ctrl: RTL

- Time-multiplexed scan controller for the board's common-anode 7-segment display bank.
- Shares a single SEG7DEC decoder instance between NDIG digit positions.
- Each scan slot: the controller presents one digit nibble to the decoder, takes back the active-low segment pattern, adds decimal point, leading-zero blanking and blink, and drives the segment bus and digit enables with a ghost-suppression gap.
- Sits between the clock/time-keeping logic (digit nibbles in) and the board pins.

---
 rtl/seg7_scan_ctrl_if.sv | 41 ++++
 rtl/seg7_scan_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_ctrl_if
//   Signal bundle between the time-keeping logic, the shared SEG7DEC decoder,
//   the board pins and the 7-segment scan controller.
//
//   digits       4*NDIG  digit nibbles, digit i = digits[4i+3:4i] (0 = LSD)
//   dp_in        NDIG    decimal point request per digit, active-high
//   lzb          1       leading-zero blanking enable
//   blink_mask   NDIG    digits subject to blinking
//   blink_phase  1       1 = off phase, masked digits go dark
//   seg_din      4       nibble presented to the shared decoder
//   seg_nhex     8       active-low pattern returned by the decoder ([6:0] used)
//   nhex         8       segment pins, active-low, bit 7 = decimal point
//   ndig         NDIG    digit enables, active-low, one-hot-low when lit
//
//   slave  : the scan controller
//   master : its environment (digit source, decoder, pins)
// -----------------------------------------------------------------------------
interface seg7_scan_ctrl_if #(
    parameter int NDIG = 4
) ();
    logic [4*NDIG-1:0] digits;
    logic [NDIG-1:0]   dp_in;
    logic              lzb;
    logic [NDIG-1:0]   blink_mask;
    logic              blink_phase;
    logic [3:0]        seg_din;
    logic [7:0]        seg_nhex;
    logic [7:0]        nhex;
    logic [NDIG-1:0]   ndig;

    modport slave (
        input  digits, dp_in, lzb, blink_mask, blink_phase, seg_nhex,
        output seg_din, nhex, ndig
    );

    modport master (
        output digits, dp_in, lzb, blink_mask, blink_phase, seg_nhex,
        input  seg_din, nhex, ndig
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_scan_ctrl
//   Time-multiplexed scan controller for a common-anode 7-segment bank. One
//   SEG7DEC instance is shared by all NDIG positions: each slot the controller
//   snapshots one digit, feeds its nibble to the decoder, and drives the
//   decoded pattern plus decimal point onto the pins, with leading-zero
//   blanking, blinking and a blank gap at slot start to avoid ghosting.
//
//   Slot timing (cnt = 0 .. SCAN_DIV-1):
//     edge at cnt == BLANK_CYC-1 : snapshot digit/flags of the current slot
//     edge at cnt == BLANK_CYC   : light the digit (unless dark)
//     edge at cnt == SCAN_DIV-1  : blank, advance to the next slot
//   Requires SCAN_DIV >= BLANK_CYC+2 and BLANK_CYC >= 1.
//
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    seg7_scan_ctrl_if.slave (digit inputs, decoder path, pins)
// -----------------------------------------------------------------------------
module seg7_scan_ctrl #(
    parameter int NDIG      = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic            clk,
    input  logic            rst_n,
    seg7_scan_ctrl_if.slave bus
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_SNAP = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_LIT  = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;

    // Snapshot of the current slot's digit, taken at the last blank cycle.
    logic [3:0]       nib;
    logic             dp;
    logic             dark;

    // Registered pin drivers.
    logic [7:0]       nhex_q;
    logic [NDIG-1:0]  ndig_q;

    // Leading-zero flags: lz_vec[i] is set when digit i and every more
    // significant digit are zero. Digit 0 is never blanked.
    logic [NDIG-1:0]  lz_vec;
    logic             upper_zero;

    // Decoder bit 7 is not a segment; the decimal point comes from dp.
    logic             unused_seg_bit7;
    assign unused_seg_bit7 = bus.seg_nhex[7];

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        upper_zero = 1'b1;
        lz_vec     = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            upper_zero = upper_zero & (bus.digits[4*i +: 4] == 4'd0);
            lz_vec[i]  = (i != 0) ? upper_zero : 1'b0;
        end
    end

    // Slot counter and digit index.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Snapshot: inputs are sampled once per slot so a change mid-slot cannot
    // tear the displayed digit.
    // NOTE: the snapshot registers are reset as well, because nib drives the
    // decoder input directly and must be a known value straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nib  <= 4'd0;
            dp   <= 1'b0;
            dark <= 1'b0;
        end else if (cnt == CNT_SNAP) begin
            nib  <= bus.digits[4*int'(idx) +: 4];
            dp   <= bus.dp_in[idx];
            dark <= (bus.lzb & lz_vec[idx]) | (bus.blink_mask[idx] & bus.blink_phase);
        end
    end

    // Pin register: enable and pattern always update on the same edge, so a
    // digit is never enabled with a stale pattern. The decoder output is stable
    // here because nib has been held since the previous edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ndig_q <= '1;
            nhex_q <= 8'hFF;
        end else if (cnt == CNT_LAST) begin
            ndig_q <= '1;
            nhex_q <= 8'hFF;
        end else if (cnt == CNT_LIT && !dark) begin
            ndig_q <= ~(NDIG'(1) << idx);
            nhex_q <= {~dp, bus.seg_nhex[6:0]};
        end
    end

    assign bus.seg_din = nib;
    assign bus.nhex    = nhex_q;
    assign bus.ndig    = ndig_q;

endmodule
